// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM controller.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x READ_LAT) -> DONE.
module ram_port_arbiter #(
   parameter int READ_LAT = 1,
   parameter int AW       = 8,
   parameter int DW       = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic          mem_write_en,
   output logic          mem_read_en,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_data_in,
   input  logic [DW-1:0] mem_data_out,
   output logic          busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [1:0] CNT_LAST = 2'(READ_LAT - 1);

   state_t        state_q, state_d;
   logic          gnt_q, gnt_d;
   logic          last_q, last_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [DW-1:0] a_rdata_q, a_rdata_d;
   logic [DW-1:0] b_rdata_q, b_rdata_d;
   logic          mem_we_q, mem_we_d;
   logic          mem_re_q, mem_re_d;
   logic          a_ack_q, a_ack_d;
   logic          b_ack_q, b_ack_d;
   logic          busy_q, busy_d;
   logic          pick_b;

   // gnt/last: 0 = port A, 1 = port B; B wins only if A idle or A went last
   assign pick_b = b_req & (~a_req | ~last_q);

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (a_req | b_req) begin
               gnt_d   = pick_b;
               last_d  = pick_b;
               we_d    = pick_b ? b_we    : a_we;
               addr_d  = pick_b ? b_addr  : a_addr;
               wdata_d = pick_b ? b_wdata : a_wdata;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = 2'd0;
            state_d = we_q ? S_DONE : S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               if (gnt_q) b_rdata_d = mem_data_out;
               else       a_rdata_d = mem_data_out;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // outputs are registered copies of what the next state implies
      mem_we_d = (state_d == S_ISSUE) & we_d;
      mem_re_d = (state_d == S_ISSUE) & ~we_d;
      a_ack_d  = (state_d == S_DONE) & ~gnt_d;
      b_ack_d  = (state_d == S_DONE) & gnt_d;
      busy_d   = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= 2'd0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         mem_we_q  <= 1'b0;
         mem_re_q  <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         mem_we_q  <= mem_we_d;
         mem_re_q  <= mem_re_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         busy_q    <= busy_d;
      end
   end

   assign mem_write_en = mem_we_q;
   assign mem_read_en  = mem_re_q;
   assign mem_address  = addr_q;
   assign mem_data_in  = wdata_q;
   assign a_ack        = a_ack_q;
   assign b_ack        = b_ack_q;
   assign a_rdata      = a_rdata_q;
   assign b_rdata      = b_rdata_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: READ_LAT=1 instance for most steps,
// READ_LAT=3 instance for the long-latency read.
module tb_ram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       a_req = 1'b0, a_we = 1'b0;
   logic [7:0] a_addr = '0, a_wdata = '0;
   logic       b_req = 1'b0, b_we = 1'b0;
   logic [7:0] b_addr = '0, b_wdata = '0;

   logic       a_ack1, b_ack1, we1, re1, busy1;
   logic [7:0] a_rd1, b_rd1, addr1, din1, dout1;
   logic       a_ack3, b_ack3, we3, re3, busy3;
   logic [7:0] a_rd3, b_rd3, addr3, din3, dout3;

   logic [7:0] mem1 [256];
   logic [7:0] mem3 [256];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ram_port_arbiter #(.READ_LAT(1), .AW(8), .DW(8)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack1), .a_rdata(a_rd1),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack1), .b_rdata(b_rd1),
      .mem_write_en(we1), .mem_read_en(re1), .mem_address(addr1),
      .mem_data_in(din1), .mem_data_out(dout1), .busy(busy1)
   );

   ram_port_arbiter #(.READ_LAT(3), .AW(8), .DW(8)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack3), .a_rdata(a_rd3),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack3), .b_rdata(b_rd3),
      .mem_write_en(we3), .mem_read_en(re3), .mem_address(addr3),
      .mem_data_in(din3), .mem_data_out(dout3), .busy(busy3)
   );

   // RAM models: address is held by the arbiter, so read data is combinational
   always @(posedge clk) if (we1) mem1[addr1] <= din1;
   always @(posedge clk) if (we3) mem3[addr3] <= din3;
   assign dout1 = mem1[addr1];
   assign dout3 = mem3[addr3];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_busy", 32'(busy1), 0);
      chk("rst_we", 32'(we1), 0);
      chk("rst_re", 32'(re1), 0);
      chk("rst_addr", 32'(addr1), 0);
      chk("rst_din", 32'(din1), 0);
      chk("rst_acks", {30'd0, a_ack1, b_ack1}, 0);
      chk("rst_rdata", {16'd0, a_rd1, b_rd1}, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // A write 0x01 <- 0xFF
      a_req = 1; a_we = 1; a_addr = 8'h01; a_wdata = 8'hFF;
      tick();
      chk("w_issue_we", 32'(we1), 1);
      chk("w_issue_re", 32'(re1), 0);
      chk("w_issue_addr", 32'(addr1), 32'h01);
      chk("w_issue_din", 32'(din1), 32'hFF);
      chk("w_issue_ack", 32'(a_ack1), 0);
      chk("w_issue_busy", 32'(busy1), 1);
      tick();
      chk("w_done_ack", 32'(a_ack1), 1);
      chk("w_done_we", 32'(we1), 0);
      tick();
      a_req = 0;
      chk("w_idle_ack", 32'(a_ack1), 0);
      chk("w_idle_busy", 32'(busy1), 0);
      chk("w_hold_addr", 32'(addr1), 32'h01);

      // A read 0x01
      a_req = 1; a_we = 0; a_addr = 8'h01;
      tick();
      chk("r_issue_re", 32'(re1), 1);
      chk("r_issue_we", 32'(we1), 0);
      tick();
      chk("r_wait_re", 32'(re1), 0);
      chk("r_wait_ack", 32'(a_ack1), 0);
      tick();
      chk("r_done_ack", 32'(a_ack1), 1);
      chk("r_rdata", 32'(a_rd1), 32'hFF);
      tick();
      a_req = 0;
      chk("r_after_ack", 32'(a_ack1), 0);
      chk("r_rdata_hold", 32'(a_rd1), 32'hFF);

      // simultaneous A write 0x02/0xAA and B read 0x02 after reset
      do_reset();
      a_req = 1; a_we = 1; a_addr = 8'h02; a_wdata = 8'hAA;
      b_req = 1; b_we = 0; b_addr = 8'h02; b_wdata = 8'h00;
      tick();
      chk("tie_first_we", 32'(we1), 1);
      chk("tie_first_addr", 32'(addr1), 32'h02);
      tick();
      chk("tie_a_ack", {30'd0, a_ack1, b_ack1}, 2);
      tick();
      a_req = 0;
      tick();
      chk("tie_b_issue_re", 32'(re1), 1);
      tick();
      tick();
      chk("tie_b_ack", {30'd0, a_ack1, b_ack1}, 1);
      chk("tie_b_rdata", 32'(b_rd1), 32'hAA);
      chk("tie_a_rdata_kept", 32'(a_rd1), 0);
      tick();
      b_req = 0;

      // both requests held: grants alternate A,B,A,B (last grant was B)
      a_req = 1; a_we = 1; a_addr = 8'h10; a_wdata = 8'h01;
      b_req = 1; b_we = 1; b_addr = 8'h11; b_wdata = 8'h02;
      for (int t = 1; t <= 12; t++) begin
         tick();
         chk($sformatf("rr_a_ack_t%0d", t), 32'(a_ack1),
             32'((t % 6) == 2));
         chk($sformatf("rr_b_ack_t%0d", t), 32'(b_ack1),
             32'((t % 6) == 5));
         if (t % 3 == 1)
            chk($sformatf("rr_addr_t%0d", t), 32'(addr1),
                (t % 6 == 1) ? 32'h10 : 32'h11);
      end
      a_req = 0;
      b_req = 0;
      tick();

      // reset during WAIT of a B read
      b_req = 1; b_we = 0; b_addr = 8'h02;
      tick();
      chk("abort_issue_re", 32'(re1), 1);
      tick();
      chk("abort_wait_busy", 32'(busy1), 1);
      rst_n = 0;
      #1;
      chk("abort_re", 32'(re1), 0);
      chk("abort_acks", {30'd0, a_ack1, b_ack1}, 0);
      chk("abort_busy", 32'(busy1), 0);
      chk("abort_b_rdata", 32'(b_rd1), 0);
      b_req = 0;
      tick();
      rst_n = 1;
      tick();
      chk("abort_no_ack", 32'(b_ack1), 0);
      a_req = 1; a_we = 1; a_addr = 8'h05; a_wdata = 8'h33;
      tick();
      chk("post_rst_we", 32'(we1), 1);
      chk("post_rst_addr", 32'(addr1), 32'h05);
      tick();
      chk("post_rst_ack", {30'd0, a_ack1, b_ack1}, 2);
      tick();
      a_req = 0;

      // READ_LAT=3: A write 0x03 <- 0x11 then B read 0x03
      do_reset();
      a_req = 1; a_we = 1; a_addr = 8'h03; a_wdata = 8'h11;
      tick();
      tick();
      chk("l3_w_ack", 32'(a_ack3), 1);
      tick();
      a_req = 0;
      b_req = 1; b_we = 0; b_addr = 8'h03;
      tick();
      chk("l3_issue_re", 32'(re3), 1);
      chk("l3_busy_issue", 32'(busy3), 1);
      for (int w = 1; w <= 3; w++) begin
         tick();
         chk($sformatf("l3_wait%0d_ack", w), 32'(b_ack3), 0);
         chk($sformatf("l3_wait%0d_busy", w), 32'(busy3), 1);
         chk($sformatf("l3_wait%0d_re", w), 32'(re3), 0);
      end
      tick();
      chk("l3_b_ack", 32'(b_ack3), 1);
      chk("l3_b_rdata", 32'(b_rd3), 32'h11);
      chk("l3_busy_done", 32'(busy3), 1);
      tick();
      b_req = 0;
      chk("l3_after_ack", 32'(b_ack3), 0);
      chk("l3_idle_busy", 32'(busy3), 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter READ_LAT, default 1: cycles from mem_read_en high to mem_data_out valid (1..4).
REQ-002 SHALL have parameter AW, default 8: address width.
REQ-003 SHALL have parameter DW, default 8: data width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 a_req  in  1  port A request; held high until a_ack.
REQ-007 a_we  in  1  port A op: 1 write, 0 read; stable while a_req.
REQ-008 a_addr  in  AW  port A address; stable while a_req.
REQ-009 a_wdata  in  DW  port A write data; stable while a_req.
REQ-010 a_ack  out  1  port A one-cycle completion pulse.
REQ-011 a_rdata  out  DW  port A read data, valid during a_ack of a read.
REQ-012 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata SHALL mirror REQ-006..011 for port B.
REQ-013 mem_write_en  out  1  write enable to ram_controller.
REQ-014 mem_read_en  out  1  read enable to ram_controller.
REQ-015 mem_address  out  AW  address to ram_controller.
REQ-016 mem_data_in  out  DW  write data to ram_controller.
REQ-017 mem_data_out  in  DW  read data from ram_controller.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, DONE; all outputs registered.
REQ-020 IDLE: when any req high at clock edge, grant one port, capture its we/addr/wdata into internal registers, go to ISSUE; else stay IDLE.
REQ-021 Arbitration round-robin: one requester -> it wins; both -> port not granted last wins; last_grant updated on each grant.
REQ-022 ISSUE lasts exactly one cycle: mem_write_en = captured we, mem_read_en = !captured we, mem_address/mem_data_in = captured values; never both enables high.
REQ-023 From ISSUE: write -> DONE; read -> WAIT.
REQ-024 WAIT lasts exactly READ_LAT cycles, enables low; mem_data_out captured into granted port's rdata register at the edge ending the last WAIT cycle; then DONE.
REQ-025 DONE lasts one cycle: granted port's ack high, other ack low; no arbitration in DONE; next state IDLE.
REQ-026 Latency, req first sampled at edge E: write ack in cycle E+2; read ack in cycle E+2+READ_LAT.
REQ-027 x_rdata SHALL hold its last captured value until the next read completion for that port; writes do not alter it.
REQ-028 Requester deasserts req at the edge ending its ack cycle; req held high past that SHALL be treated as a new request.
REQ-029 Requests arriving outside IDLE are not lost: they wait, held high, until next IDLE.
REQ-030 mem_address and mem_data_in SHALL hold captured values outside ISSUE; only enables gate the RAM.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, mem_write_en=0, mem_read_en=0, mem_address=0, mem_data_in=0, a_ack=b_ack=0, a_rdata=b_rdata=0, busy=0, last_grant=B (A wins first tie).
REQ-032 Reset mid-transaction SHALL abort it with no ack; operation resumes at IDLE on first edge after rst_n rises.

Verification
REQ-033 A write addr 0x01 data 0xFF, READ_LAT=1 -> one ISSUE cycle mem_write_en=1, mem_address=0x01, mem_data_in=0xFF; a_ack two cycles after req sampled.
REQ-034 A read 0x01 after REQ-033, model returns 0xFF -> mem_read_en one cycle, a_ack three cycles after req sampled, a_rdata=0xFF.
REQ-035 A and B request simultaneously after reset (A write 0x02/0xAA, B read 0x02) -> A served first, then B; b_rdata=0xAA.
REQ-036 A and B hold req continuously for 4 transactions -> grants alternate A,B,A,B; exactly one ack per transaction.
REQ-037 rst_n low during WAIT of B read -> enables and acks low immediately, no b_ack, b_rdata=0; new A write after release completes normally.
REQ-038 READ_LAT=3, B read 0x03 holding 0x11 -> b_ack five cycles after req sampled, b_rdata=0x11, busy high throughout.
